// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/arbiter bus bundle for reg_write_arbiter
//
// Purpose: groups the requester-facing and register-facing signals of the
// shared-register write arbiter so they travel as one port.
//
// Signals:
//   req     [N]        per-requester write request (level)
//   lock    [N]        per-requester lock hint (used only with ARB_LOCK_EN)
//   dataIn  [N*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   grant   [N]        one-hot, high while the owner's transfer is in LOAD
//   ack     [N]        one-hot, one-cycle pulse once the owner's data is stored
//   q       [WIDTH]    stored word
//   qBar    [WIDTH]    bitwise complement of q
//   busy               high in LOAD or ACK
//
// Modports: master = requester side, slave = arbiter side.
interface reg_write_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req;
  logic [N-1:0]       lock;
  logic [N*WIDTH-1:0] dataIn;
  logic [N-1:0]       grant;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qBar;
  logic               busy;

  modport master (
    output req, lock, dataIn,
    input  grant, ack, q, qBar, busy
  );

  modport slave (
    input  req, lock, dataIn,
    output grant, ack, q, qBar, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter owning the shared storage register
//
// Purpose: grants one of N requesters at a time, loads its WIDTH-bit word into
// the shared register, acknowledges it, and advances the round-robin pointer.
// A transfer is IDLE -> LOAD -> ACK -> IDLE (one transfer per 3 cycles).
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of reg_write_arbiter_if (req, lock, dataIn in;
//          grant, ack, q, qBar, busy out)
//
// Optional feature (macro ARB_LOCK_EN): a requester holding lock and req in
// ACK is re-granted directly (ACK -> LOAD) for up to 4 consecutive transfers,
// tracked by a 2-bit lockCnt. Without the macro, lock is ignored.
module reg_write_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  reg_write_arbiter_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_q, q_d;

`ifdef ARB_LOCK_EN
  logic [1:0]       lock_cnt_q, lock_cnt_d;
`else
  logic             unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  // Winner search: first set req bit at or after ptr, wrapping modulo N.
  logic [IW-1:0]    win;
  logic             win_found;
  logic [IW-1:0]    ptr_next;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(ptr_q) + k;
      if (c >= N) c = c - N;
      if (!win_found && bus.req[IW'(c)]) begin
        win       = IW'(c);
        win_found = 1'b1;
      end
    end
  end

  // Pointer wraps explicitly so non-power-of-two N works.
  assign ptr_next = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) sel_data = bus.dataIn[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    q_d     = q_q;
    grant_d = '0;
    ack_d   = '0;
    busy_d  = 1'b0;
`ifdef ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d   = win;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Data is captured even if req has dropped: a granted transfer always completes.
        q_d     = sel_data;
        state_d = ACK;
      end
      ACK: begin
`ifdef ARB_LOCK_EN
        if (bus.lock[idx_q] && bus.req[idx_q] && (lock_cnt_q != 2'd3)) begin
          state_d    = LOAD;
          lock_cnt_d = lock_cnt_q + 2'd1;
        end else begin
          state_d    = IDLE;
          ptr_d      = ptr_next;
          lock_cnt_d = 2'd0;
        end
`else
        state_d = IDLE;
        ptr_d   = ptr_next;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered.
    if (state_d == LOAD) grant_d[idx_d] = 1'b1;
    if (state_d == ACK)  ack_d[idx_d]   = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      q_q     <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_q;
  assign bus.qBar  = ~q_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  reg_write_arbiter_if #(.N(4), .WIDTH(8)) bus ();

  reg_write_arbiter #(.N(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.req    = 4'b1111;
    bus.lock   = 4'b0000;
    bus.dataIn = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    tick();
    tick();
    tests_run++; if (bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
    tests_run++; if (bus.ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
    tests_run++; if (bus.q !== 8'h00) begin tests_failed++; $display("FAIL reset_q got=%h exp=00", bus.q); end
    tests_run++; if (bus.qBar !== 8'hFF) begin tests_failed++; $display("FAIL reset_qBar got=%h exp=ff", bus.qBar); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    reset   = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    tests_run++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL idle_no_req got busy=%b grant=%b exp busy=0 grant=0000", bus.busy, bus.grant); end
  endtask

  task automatic test_single();
    bus.req    = 4'b0001;
    bus.dataIn = {8'h00, 8'h00, 8'h00, 8'hA5};
    tick();
    tests_run++; if (bus.grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant got=%b exp=0001", bus.grant); end
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_load got=%b exp=1", bus.busy); end
    tests_run++; if (bus.ack !== 4'b0000 || bus.q !== 8'h00) begin tests_failed++; $display("FAIL single_load_early got ack=%b q=%h exp ack=0000 q=00", bus.ack, bus.q); end
    tick();
    tests_run++; if (bus.grant !== 4'b0000) begin tests_failed++; $display("FAIL single_grant_drop got=%b exp=0000", bus.grant); end
    tests_run++; if (bus.ack !== 4'b0001) begin tests_failed++; $display("FAIL single_ack got=%b exp=0001", bus.ack); end
    tests_run++; if (bus.q !== 8'hA5) begin tests_failed++; $display("FAIL single_q got=%h exp=a5", bus.q); end
    tests_run++; if (bus.qBar !== 8'h5A) begin tests_failed++; $display("FAIL single_qBar got=%h exp=5a", bus.qBar); end
    bus.req = 4'b0000;
    tick();
    tests_run++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle got ack=%b busy=%b exp ack=0000 busy=0", bus.ack, bus.busy); end
    tests_run++; if (bus.q !== 8'hA5) begin tests_failed++; $display("FAIL single_q_hold got=%h exp=a5", bus.q); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic [7:0] exp_q;
    do_reset();
    bus.req    = 4'b1111;
    bus.dataIn = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int t = 0; t < 5; t++) begin
      exp_oh = 4'b0001 << (t % 4);
      exp_q  = 8'h10 + 8'(t % 4);
      tick();
      tests_run++; if (bus.grant !== exp_oh) begin tests_failed++; $display("FAIL rr_grant[%0d] got=%b exp=%b", t, bus.grant, exp_oh); end
      tick();
      tests_run++; if (bus.ack !== exp_oh) begin tests_failed++; $display("FAIL rr_ack[%0d] got=%b exp=%b", t, bus.ack, exp_oh); end
      tests_run++; if (bus.q !== exp_q) begin tests_failed++; $display("FAIL rr_q[%0d] got=%h exp=%h", t, bus.q, exp_q); end
      tick();
      tests_run++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin tests_failed++; $display("FAIL rr_idle[%0d] got busy=%b ack=%b exp busy=0 ack=0000", t, bus.busy, bus.ack); end
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    bus.req    = 4'b0100;
    bus.dataIn = {8'h44, 8'hC3, 8'h22, 8'h55};
    tick();
    tests_run++; if (bus.grant !== 4'b0100) begin tests_failed++; $display("FAIL wrap_first_grant got=%b exp=0100", bus.grant); end
    tick();
    tests_run++; if (bus.ack !== 4'b0100 || bus.q !== 8'hC3) begin tests_failed++; $display("FAIL wrap_first_ack got ack=%b q=%h exp ack=0100 q=c3", bus.ack, bus.q); end
    bus.req = 4'b0101;
    tick();
    tick();
    tests_run++; if (bus.grant !== 4'b0001) begin tests_failed++; $display("FAIL wrap_to_0_grant got=%b exp=0001", bus.grant); end
    tick();
    tests_run++; if (bus.ack !== 4'b0001 || bus.q !== 8'h55) begin tests_failed++; $display("FAIL wrap_to_0_ack got ack=%b q=%h exp ack=0001 q=55", bus.ack, bus.q); end
    tick();
    tick();
    tests_run++; if (bus.grant !== 4'b0100) begin tests_failed++; $display("FAIL skip_to_2_grant got=%b exp=0100", bus.grant); end
    tick();
    tests_run++; if (bus.ack !== 4'b0100 || bus.q !== 8'hC3) begin tests_failed++; $display("FAIL skip_to_2_ack got ack=%b q=%h exp ack=0100 q=c3", bus.ack, bus.q); end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req    = 4'b0010;
    bus.dataIn = {8'h00, 8'h00, 8'h77, 8'h3C};
    tick();
    tick();
    tests_run++; if (bus.ack !== 4'b0010 || bus.q !== 8'h77) begin tests_failed++; $display("FAIL mid_pre_ack got ack=%b q=%h exp ack=0010 q=77", bus.ack, bus.q); end
    bus.req = 4'b0001;
    tick();
    tick();
    tests_run++; if (bus.grant !== 4'b0001) begin tests_failed++; $display("FAIL mid_grant got=%b exp=0001", bus.grant); end
    reset = 1'b1;
    tick();
    tests_run++; if (bus.q !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_q got=%h exp=00", bus.q); end
    tests_run++; if (bus.ack !== 4'b0000 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_outs got ack=%b grant=%b busy=%b exp 0000 0000 0", bus.ack, bus.grant, bus.busy); end
    reset   = 1'b0;
    bus.req = 4'b1111;
    tick();
    tests_run++; if (bus.grant !== 4'b0001 || bus.ack !== 4'b0000) begin tests_failed++; $display("FAIL mid_ptr_cleared got grant=%b ack=%b exp grant=0001 ack=0000", bus.grant, bus.ack); end
    tick();
    tests_run++; if (bus.ack !== 4'b0001 || bus.q !== 8'h3C) begin tests_failed++; $display("FAIL mid_after_ack got ack=%b q=%h exp ack=0001 q=3c", bus.ack, bus.q); end
    bus.req = 4'b0000;
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.req    = 4'b0011;
    bus.lock   = 4'b0001;
    bus.dataIn = {8'h00, 8'h00, 8'hB1, 8'hA0};
    tick();
    tests_run++; if (bus.grant !== 4'b0001) begin tests_failed++; $display("FAIL lock_first_grant got=%b exp=0001", bus.grant); end
    for (int a = 0; a < 4; a++) begin
      tick();
      tests_run++; if (bus.ack !== 4'b0001 || bus.q !== 8'hA0) begin tests_failed++; $display("FAIL lock_ack[%0d] got ack=%b q=%h exp ack=0001 q=a0", a, bus.ack, bus.q); end
      tick();
      if (a < 3) begin
        tests_run++; if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL lock_regrant[%0d] got grant=%b busy=%b exp grant=0001 busy=1", a, bus.grant, bus.busy); end
      end else begin
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL lock_release got busy=%b exp=0", bus.busy); end
      end
    end
    tick();
    tests_run++; if (bus.grant !== 4'b0010) begin tests_failed++; $display("FAIL lock_other_grant got=%b exp=0010", bus.grant); end
    tick();
    tests_run++; if (bus.ack !== 4'b0010 || bus.q !== 8'hB1) begin tests_failed++; $display("FAIL lock_other_ack got ack=%b q=%h exp ack=0010 q=b1", bus.ack, bus.q); end
    tick();
    tick();
    tests_run++; if (bus.grant !== 4'b0001) begin tests_failed++; $display("FAIL lock_back_to_0 got=%b exp=0001", bus.grant); end
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    tick();
    tick();
    tick();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.req      = '0;
    bus.lock     = '0;
    bus.dataIn   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter for the shared DFF-based storage register. Up to `N` requesters compete to load a `WIDTH`-bit value into one register. The block grants one requester at a time, loads its data, acknowledges it, and exposes the stored value as `q` and its complement `qBar`. It sits between the requester datapaths and the shared register, and is the only writer of that register.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `WIDTH`, 8, stored word width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  N  per-requester write request, level
- `lock`  in  N  per-requester lock hint; ignored unless `ARB_LOCK_EN` is defined
- `dataIn`  in  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- `grant`  out  N  one-hot, high while requester's transfer is in LOAD
- `ack`  out  N  one-hot, one-cycle pulse when requester's data has been stored
- `q`  out  WIDTH  stored word
- `qBar`  out  WIDTH  bitwise complement of `q`, always
- `busy`  out  1  high in LOAD or ACK

## Operation
- FSM states: IDLE, LOAD, ACK.
- IDLE: if `req` is nonzero, select the winner. The winner is the first set bit at or after `ptr`, scanning upward and wrapping modulo N. Register it as `idx` and go to LOAD. Otherwise stay in IDLE.
- LOAD: `grant[idx]`=1. At the next edge, `q` <= `dataIn[idx]` and the state goes to ACK. The data is taken at this edge even if `req[idx]` has dropped, so the transfer always completes.
- ACK: `ack[idx]`=1. At the next edge, `ptr` <= (`idx`+1) mod N and the state goes to IDLE.
- Requesters must drop `req` on seeing `ack`. A request still held in IDLE is re-arbitrated normally.
- Fairness: a requester that keeps `req` high waits at most N-1 other transfers.
- `req` bits that change during LOAD or ACK have no effect until the block is back in IDLE.
- `q` changes only at the LOAD→ACK edge and on reset.

## Timing
- Reset (synchronous, `reset`=1 at an edge): state=IDLE, `ptr`=0, `idx`=0, `grant`=0, `ack`=0, `busy`=0, `q`=0, `qBar`=all ones. Reset takes priority over every transition, including mid-LOAD and mid-ACK. An interrupted transfer does not write `q` and produces no `ack`.
- Request sampled in IDLE at edge E0:
  - `grant` and `busy` high after E0.
  - `q` updated at E1; `ack` high for one cycle after E1.
  - State is IDLE after E2.
  - Next arbitration happens at E3.
- Throughput: one transfer per 3 cycles. Latency from `req` sampled to `q` valid: 2 edges.
- `grant`, `ack` and `busy` are registered outputs. `qBar` is combinational from `q`.
- Simultaneous requests: exactly one grant, chosen by `ptr` order. At most one bit of `grant` and one bit of `ack` is ever set.
- `ptr` wraps from N-1 to 0.

## Configuration
- `ARB_LOCK_EN` defined: the ACK state gains an extra transition.
  - Condition: `lock[idx]` and `req[idx]` both high in ACK.
  - Action: go directly to LOAD with the same `idx`; `ptr` is not advanced; a 2-bit `lockCnt` increments.
  - `lockCnt`=3 means 4 consecutive locked transfers have been made. The next ACK then ignores `lock`, goes to IDLE, advances `ptr` and clears `lockCnt`.
  - `lockCnt` is also cleared on every normal ACK→IDLE transition and on reset.
  - Locked throughput: one transfer per 2 cycles.
- `ARB_LOCK_EN` undefined: `lock` is unused and no `lockCnt` is built. Behaviour is exactly the base FSM.

## Test plan
- Reset check: assert `reset` for 2 cycles with all `req` high → `grant`=0, `ack`=0, `q`=0x00, `qBar`=0xFF, `busy`=0.
- Single write: N=4, `req`=0001, `dataIn[0]`=0xA5 → `grant`=0001 for 1 cycle; then `q`=0xA5, `qBar`=0x5A, `ack`=0001 for 1 cycle; back to IDLE on the 3rd edge.
- Round-robin: `req`=1111 held, data i=0x10+i → ack order 0,1,2,3,0. `q` sequence is 0x10, 0x11, 0x12, 0x13, 0x10, with one transfer every 3 cycles.
- Wrap and skip: `ptr`=3 after a grant to 2, then `req`=0101 → grant to 0; next grant to 2.
- Reset mid-op: `reset` at the LOAD edge of a 0x3C write → `q` stays at its prior value (0 after reset), no `ack`, `ptr`=0.
- With `ARB_LOCK_EN`: `req`=0011, `lock`=0001 held → requester 0 gets 4 consecutive acks spaced 2 cycles apart, then requester 1 gets one ack, then requester 0 again.
